par_bus_transceiver: RTL and testbench
======================================

Name: par_bus_transceiver

Overview:
Parametrised, buffered successor to the 8-bit Pi-to-FPGA parallel bus receiver/transmitter pair, combined into one block.
- Synchronises the master-clocked bus (bus_clk, bus_rnw, bus_data) into the fast clk domain.
- Performs an edge-qualified two-word sync handshake.
- Buffers received words in an RX FIFO and words to send in a TX FIFO, both with valid/ready handshakes toward the MD5 core side.
- Adds configurable width, FIFO depths, overflow reporting and abort/resend on direction change.

Parameters:
DATA_W, 8, bus and FIFO word width
RX_DEPTH, 16, RX FIFO entries (power of 2, >=2)
TX_DEPTH, 16, TX FIFO entries (power of 2, >=2)
SYNC_WORD1, 8'hB8 (DATA_W wide), first sync word
SYNC_WORD2, 8'h8B (DATA_W wide), second sync word
SYNC_STAGES, 2, synchroniser flops on bus inputs (>=2)

Ports:
clk  in  1  fast system clock (~100 MHz)
reset  in  1  synchronous, active-low reset
desync  in  1  drop sync, return to hunting
bus_clk  in  1  master strobe
bus_rnw  in  1  1 = master reads (FPGA drives), 0 = master writes
bus_data_in  in  DATA_W  bus data from master
bus_data_out  out  DATA_W  bus data to master
bus_data_oe  out  1  tristate enable for bus_data_out
rx_data  out  DATA_W  RX FIFO head (show-ahead)
rx_valid  out  1  RX FIFO non-empty
rx_ready  in  1  consumer pops head when rx_valid & rx_ready
tx_data  in  DATA_W  word to transmit
tx_valid  in  1  push request
tx_ready  out  1  TX FIFO not full
synced  out  1  sync handshake complete
rx_overflow  out  1  sticky: a received word was dropped
rx_count  out  $clog2(RX_DEPTH)+1  RX occupancy
tx_count  out  $clog2(TX_DEPTH)+1  TX occupancy

Behaviour:
- reset low at a clk edge: all flops cleared; every output 0, FIFOs empty, sync FSM SYNC1, TX FSM IDLE. Reset mid-transfer discards all state; no partial word is emitted.
- Synchroniser: SYNC_STAGES flops on each bus input, plus one extra bus_clk stage for edge detection. A rise is when the last stage is 1 and the extra stage is 0 (one-cycle pulse).
- Sync FSM (advances only on bus_clk rise with rnw_s=0):
  - SYNC1 -> SYNC2 on SYNC_WORD1.
  - SYNC2 -> DONE on SYNC_WORD2; stays in SYNC2 on SYNC_WORD1; any other word returns to SYNC1.
  - DONE: synced=1. desync=1 -> SYNC1, with synced=0 and rx_overflow cleared on the next cycle.
  - Sync words are never pushed into the RX FIFO.
- RX path:
  - On a bus_clk rise with rnw_s=0 and synced=1, data_s is pushed.
  - Latency: rx_valid=1 exactly SYNC_STAGES+2 cycles after the first clk edge that samples bus_clk high (FIFO empty, stable data).
  - Full with a simultaneous pop: push accepted.
  - Full without a pop: word dropped and rx_overflow set; it stays set until reset or desync.
- TX FSM:
  - IDLE: if rnw_s=1 and TX FIFO non-empty, pop into hold register, set hold_valid, go to WAIT_LOW. If hold_valid is already set, go to WAIT_LOW without popping.
  - WAIT_LOW: when bus_clk_s=0, drive bus_data_out=hold, go to WAIT_HIGH.
  - WAIT_HIGH: when bus_clk_s=1, clear hold_valid, go to IDLE.
  - rnw_s falling to 0 in WAIT_LOW/WAIT_HIGH: go to IDLE with hold_valid kept, so the word is resent at the next read phase. No word is lost or duplicated.
- bus_data_oe = rnw_s (registered). bus_data_out holds its last value when not updated.
- TX push occurs when tx_valid & tx_ready. A simultaneous push and pop on a full TX FIFO is allowed.
- Counts update in the same cycle as push/pop; a simultaneous push and pop leaves the count unchanged.
- FIFO pointers wrap modulo depth; count uses the extra MSB to distinguish full from empty.

Decomposition:
- Shared package par_bus_pkg: sync FSM state constants (SYNC1, SYNC2, DONE), TX FSM constants (IDLE, WAIT_LOW, WAIT_HIGH), default sync words.
- One sub-module: par_bus_fifo (single-clock, show-ahead, parametrised DATA_W/DEPTH, push/pop/full/empty/count), instantiated twice.

Test Plan:
- Sync and receive: reset low 5 cycles, master writes B8, 8B, 11, 22, 33 -> synced=1 after 8B; rx_data sequence 11, 22, 33; rx_count peaks at 3; B8/8B never appear.
- Sync restart: master writes B8, 44, B8, B8, 8B -> synced only after the final 8B; no words pushed before it.
- Overflow: rx_ready=0, write RX_DEPTH+2 words after sync -> rx_count=16, rx_overflow=1, first 16 words read back intact; desync clears rx_overflow and synced.
- Transmit: push A1, A2, A3 with rnw=1 and 3 master strobes -> master samples A1, A2, A3 on bus_clk rise; bus_data_oe=1; tx_count returns to 0.
- Abort and resend: rnw dropped after bus_clk goes low while A1 is driven -> on next read phase the master receives A1 then A2; no duplicate or loss.
- Reset mid-operation: assert reset during WAIT_HIGH with 2 RX words queued -> all outputs 0, counts 0, synced=0 the next cycle.

Source files
------------

// File: rtl/par_bus_pkg.sv
// par_bus_pkg: shared FSM state types and default sync words for the parallel bus transceiver
package par_bus_pkg;
  typedef enum logic [1:0] {SYNC1, SYNC2, DONE} sync_state_t;
  typedef enum logic [1:0] {IDLE, WAIT_LOW, WAIT_HIGH} tx_state_t;
  localparam logic [7:0] DEF_SYNC_WORD1 = 8'hB8;
  localparam logic [7:0] DEF_SYNC_WORD2 = 8'h8B;
endpackage

// File: rtl/par_bus_fifo.sv
// par_bus_fifo: single-clock show-ahead FIFO; push on full is accepted only alongside a pop
module par_bus_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign count = wr_ptr - rd_ptr;
  assign empty = count == '0;
  assign full = count[AW];
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ONE;
      if (do_pop) rd_ptr <= rd_ptr + ONE;
    end
  end
  always_ff @(posedge clk) if (do_push) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/par_bus_transceiver.sv
// par_bus_transceiver: synchronised master-clocked parallel bus with sync handshake and RX/TX FIFOs
module par_bus_transceiver import par_bus_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int RX_DEPTH = 16,
  parameter int TX_DEPTH = 16,
  parameter logic [DATA_W-1:0] SYNC_WORD1 = DATA_W'(DEF_SYNC_WORD1),
  parameter logic [DATA_W-1:0] SYNC_WORD2 = DATA_W'(DEF_SYNC_WORD2),
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          desync,
  input  logic                          bus_clk,
  input  logic                          bus_rnw,
  input  logic [DATA_W-1:0]             bus_data_in,
  output logic [DATA_W-1:0]             bus_data_out,
  output logic                          bus_data_oe,
  output logic [DATA_W-1:0]             rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  input  logic [DATA_W-1:0]             tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          synced,
  output logic                          rx_overflow,
  output logic [$clog2(RX_DEPTH):0]     rx_count,
  output logic [$clog2(TX_DEPTH):0]     tx_count
);
  logic [SYNC_STAGES-1:0] clk_sr, rnw_sr;
  logic [DATA_W-1:0] data_sr [SYNC_STAGES];
  logic bus_clk_s, rnw_s, clk_d, wr_ev, push_q, push_next;
  logic [DATA_W-1:0] data_s, data_q, push_data, hold, tx_dout;
  sync_state_t sync_state, sync_next;
  tx_state_t tx_state, tx_next;
  logic hold_valid, tx_pop, drive, sent, rx_full, rx_empty, rx_pop, tx_full, tx_empty;
  assign bus_clk_s = clk_sr[SYNC_STAGES-1];
  assign rnw_s = rnw_sr[SYNC_STAGES-1];
  assign data_s = data_sr[SYNC_STAGES-1];
  assign synced = sync_state == DONE;
  assign rx_valid = ~rx_empty;
  assign rx_pop = rx_valid & rx_ready;
  assign tx_ready = reset & (~tx_full | tx_pop);
  always_ff @(posedge clk) begin
    if (!reset) begin
      clk_sr <= '0;
      rnw_sr <= '0;
      data_sr <= '{default: '0};
      clk_d <= 1'b0;
      wr_ev <= 1'b0;
      data_q <= '0;
    end else begin
      clk_sr <= {clk_sr[SYNC_STAGES-2:0], bus_clk};
      rnw_sr <= {rnw_sr[SYNC_STAGES-2:0], bus_rnw};
      data_sr[0] <= bus_data_in;
      for (int i = 1; i < SYNC_STAGES; i++) data_sr[i] <= data_sr[i-1];
      clk_d <= bus_clk_s;
      wr_ev <= bus_clk_s & ~clk_d & ~rnw_s;
      data_q <= data_s;
    end
  end
  // Handshake words are consumed here; only words arriving while already synced reach the FIFO.
  always_comb begin
    sync_next = desync ? SYNC1 : !wr_ev ? sync_state : sync_state == DONE ? DONE :
                (sync_state == SYNC2 && data_q == SYNC_WORD2) ? DONE :
                data_q == SYNC_WORD1 ? SYNC2 : SYNC1;
    push_next = ~desync & wr_ev & (sync_state == DONE);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_state <= SYNC1;
      push_q <= 1'b0;
      push_data <= '0;
      rx_overflow <= 1'b0;
    end else begin
      sync_state <= sync_next;
      push_q <= push_next;
      push_data <= data_q;
      rx_overflow <= desync ? 1'b0 : rx_overflow | (push_q & rx_full & ~rx_pop);
    end
  end
  // Losing rnw mid-transfer keeps hold_valid so the same word is resent next read phase.
  always_comb begin
    tx_next = tx_state;
    tx_pop = 1'b0;
    drive = 1'b0;
    sent = 1'b0;
    case (tx_state)
      IDLE: begin
        tx_next = (rnw_s && (hold_valid || !tx_empty)) ? WAIT_LOW : IDLE;
        tx_pop = rnw_s & ~hold_valid & ~tx_empty;
      end
      WAIT_LOW: begin
        tx_next = !rnw_s ? IDLE : !bus_clk_s ? WAIT_HIGH : WAIT_LOW;
        drive = rnw_s & ~bus_clk_s;
      end
      WAIT_HIGH: begin
        tx_next = (!rnw_s || bus_clk_s) ? IDLE : WAIT_HIGH;
        sent = rnw_s & bus_clk_s;
      end
      default: tx_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_state <= IDLE;
      hold <= '0;
      hold_valid <= 1'b0;
      bus_data_out <= '0;
      bus_data_oe <= 1'b0;
    end else begin
      tx_state <= tx_next;
      if (tx_pop) hold <= tx_dout;
      hold_valid <= tx_pop ? 1'b1 : sent ? 1'b0 : hold_valid;
      if (drive) bus_data_out <= hold;
      bus_data_oe <= rnw_s;
    end
  end
  par_bus_fifo #(.DATA_W(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(push_q), .pop(rx_pop), .din(push_data),
    .dout(rx_data), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );
  par_bus_fifo #(.DATA_W(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(tx_valid & tx_ready), .pop(tx_pop), .din(tx_data),
    .dout(tx_dout), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );
endmodule

// File: tb/tb_par_bus_transceiver.sv
// tb_par_bus_transceiver: directed + randomized checks against a queue-based model of the bus protocol
module tb_par_bus_transceiver;
  localparam int W = 8;
  localparam int D = 16;
  logic clk = 0, reset = 0, desync = 0, bus_clk = 0, bus_rnw = 0, rx_ready = 0, tx_valid = 0;
  logic [W-1:0] bus_data_in = '0, tx_data = '0;
  logic [W-1:0] bus_data_out, rx_data;
  logic bus_data_oe, rx_valid, tx_ready, synced, rx_overflow;
  logic [4:0] rx_count, tx_count;
  int total = 0, bad = 0;
  logic [7:0] rxq[$], txq[$];
  int ss = 0;
  bit ovf = 0;
  logic [7:0] v, w;
  logic [7:0] restart_seq [5];
  always #5 clk = ~clk;
  par_bus_transceiver dut (
    .clk(clk), .reset(reset), .desync(desync), .bus_clk(bus_clk), .bus_rnw(bus_rnw),
    .bus_data_in(bus_data_in), .bus_data_out(bus_data_out), .bus_data_oe(bus_data_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .synced(synced), .rx_overflow(rx_overflow),
    .rx_count(rx_count), .tx_count(tx_count)
  );
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] rnd_word();
    logic [7:0] r;
    r = 8'($urandom);
    return (r == 8'hB8 || r == 8'h8B) ? r ^ 8'h01 : r;
  endfunction
  task automatic model_write(input logic [7:0] d);
    if (ss == 2) begin
      if (rxq.size() < D) rxq.push_back(d);
      else ovf = 1;
    end else ss = (ss == 1 && d == 8'h8B) ? 2 : (d == 8'hB8) ? 1 : 0;
  endtask
  task automatic mwrite(input logic [7:0] d);
    bus_rnw = 0; bus_data_in = d; bus_clk = 0;
    cyc(6);
    bus_clk = 1;
    cyc(6);
    model_write(d);
  endtask
  task automatic mread(output logic [7:0] r);
    bus_rnw = 1; bus_clk = 0;
    cyc(8);
    r = bus_data_out;
    chk("read_oe", bus_data_oe, 1);
    bus_clk = 1;
    cyc(8);
  endtask
  task automatic rx_take(input string tag);
    chk({tag, "_valid"}, rx_valid, 1);
    chk(tag, rx_data, rxq.pop_front());
    rx_ready = 1;
    cyc(1);
    rx_ready = 0;
  endtask
  task automatic tx_push(input logic [7:0] d);
    chk("tx_ready", tx_ready, 1);
    tx_data = d; tx_valid = 1;
    cyc(1);
    tx_valid = 0;
    txq.push_back(d);
  endtask
  task automatic do_desync();
    desync = 1;
    cyc(1);
    desync = 0;
    ss = 0; ovf = 0;
  endtask
  initial begin
    restart_seq = '{8'hB8, 8'h44, 8'hB8, 8'hB8, 8'h8B};
    cyc(5);
    chk("reset_outputs", {bus_data_out, bus_data_oe, rx_data, rx_valid, tx_ready, synced,
        rx_overflow, rx_count, tx_count}, 0);
    reset = 1;
    cyc(1);
    chk("idle_tx_ready", tx_ready, 1);
    mwrite(8'hB8);
    chk("after_sw1_synced", synced, 0);
    mwrite(8'h8B);
    chk("after_sw2_synced", synced, 1);
    chk("sync_words_not_queued", rx_count, rxq.size());
    bus_rnw = 0; bus_data_in = 8'h11; bus_clk = 0;
    cyc(6);
    bus_clk = 1;
    cyc(4);
    chk("latency_early", rx_valid, 0);
    cyc(1);
    chk("latency_exact", rx_valid, 1);
    cyc(1);
    model_write(8'h11);
    mwrite(8'h22);
    mwrite(8'h33);
    chk("rx_count_peak", rx_count, 3);
    for (int i = 0; i < 3; i++) rx_take("rx_word");
    chk("rx_drained", rx_count, 0);
    do_desync();
    chk("desync_synced", synced, 0);
    for (int i = 0; i < 5; i++) begin
      mwrite(restart_seq[i]);
      chk("restart_synced", synced, 32'(ss == 2));
      chk("restart_count", rx_count, rxq.size());
    end
    for (int i = 0; i < D + 2; i++) mwrite(rnd_word());
    chk("ovf_count", rx_count, rxq.size());
    chk("ovf_flag", rx_overflow, 32'(ovf));
    for (int i = 0; i < D; i++) rx_take("ovf_word");
    chk("ovf_empty", rx_valid, 0);
    chk("ovf_sticky", rx_overflow, 1);
    do_desync();
    chk("desync_clears_ovf", rx_overflow, 0);
    chk("desync_clears_sync", synced, 0);
    tx_push(8'hA1);
    tx_push(8'hA2);
    tx_push(8'hA3);
    chk("tx_count_full3", tx_count, 3);
    for (int i = 0; i < 3; i++) begin
      mread(v);
      chk("tx_word", v, txq.pop_front());
    end
    chk("tx_count_drained", tx_count, 0);
    tx_push(rnd_word());
    tx_push(rnd_word());
    bus_rnw = 1; bus_clk = 0;
    cyc(8);
    chk("abort_first_drive", bus_data_out, txq[0]);
    bus_rnw = 0;
    cyc(8);
    chk("abort_oe_low", bus_data_oe, 0);
    for (int i = 0; i < 2; i++) begin
      mread(v);
      chk("resend_word", v, txq.pop_front());
    end
    chk("resend_drained", tx_count, 0);
    mwrite(8'hB8);
    mwrite(8'h8B);
    mwrite(rnd_word());
    mwrite(rnd_word());
    chk("pre_reset_rx", rx_count, rxq.size());
    w = rnd_word();
    tx_push(w);
    bus_rnw = 1; bus_clk = 0;
    cyc(8);
    chk("pre_reset_drive", bus_data_out, w);
    reset = 0;
    cyc(1);
    chk("midop_reset_outputs", {bus_data_out, bus_data_oe, rx_data, rx_valid, tx_ready, synced,
        rx_overflow, rx_count, tx_count}, 0);
    bus_rnw = 0;
    rxq.delete(); txq.delete(); ss = 0; ovf = 0;
    reset = 1;
    cyc(4);
    chk("post_reset_counts", {rx_count, tx_count}, 0);
    chk("post_reset_synced", synced, 0);
    chk("post_reset_oe", bus_data_oe, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
